// File: rtl/dcm_lock_supervisor.sv
// DCM reset/lock sequencer: pulses DCM RST, waits for LOCKED with a timeout and
// bounded retries, and holds the core reset until the lock has settled.
module dcm_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dcm_locked,
  input  logic       dcm_clkin_stop,
  input  logic       relock_req,
  output logic       dcm_rst,
  output logic       sys_reset,
  output logic       clk_ok,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  localparam int unsigned RETRY_W  = 4;
  localparam int unsigned LOSS_W   = 8;
  localparam int unsigned SPAN_A   = (LOCK_TIMEOUT > SETTLE_CYCLES) ? LOCK_TIMEOUT : SETTLE_CYCLES;
  localparam int unsigned CNT_SPAN = (SPAN_A > RST_CYCLES) ? SPAN_A : RST_CYCLES;
  localparam int unsigned CNT_W    = (CNT_SPAN > 1) ? $clog2(CNT_SPAN) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(MAX_RETRIES);
  localparam logic [LOSS_W-1:0]  LOSS_MAX    = '1;

  typedef enum logic [2:0] {
    ST_DCM_RST,
    ST_WAIT_LOCK,
    ST_SETTLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [LOSS_W-1:0]  loss_nxt;

  logic lk_meta;
  logic lk_s;
  logic st_meta;
  logic st_s;
  logic lock_bad;

  // Two-flop synchronizers for the asynchronous DCM status lines
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lk_meta <= 1'b0;
      lk_s    <= 1'b0;
      st_meta <= 1'b0;
      st_s    <= 1'b0;
    end else begin
      lk_meta <= dcm_locked;
      lk_s    <= lk_meta;
      st_meta <= dcm_clkin_stop;
      st_s    <= st_meta;
    end
  end

  assign lock_bad = ~lk_s | st_s;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_DCM_RST;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      dcm_rst   <= 1'b1;
      sys_reset <= 1'b1;
      clk_ok    <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      dcm_rst   <= (state_nxt == ST_DCM_RST);
      sys_reset <= (state_nxt != ST_RUN);
      clk_ok    <= (state_nxt == ST_RUN);
      fault     <= (state_nxt == ST_FAULT);
    end
  end

  // Next-state logic; every exit clears cnt, counting states terminate before wrap
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    unique case (state)
      ST_DCM_RST: begin
        if (relock_req) begin
          cnt_nxt = '0;
        end else if (cnt == RST_LAST) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (relock_req) begin
          state_nxt = ST_DCM_RST;
          cnt_nxt   = '0;
        end else if (lk_s) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = '0;
        end else if (cnt == LOCK_LAST) begin
          retry_nxt = retry_cnt + RETRY_W'(1);
          state_nxt = (retry_nxt == RETRY_LIM) ? ST_FAULT : ST_DCM_RST;
          cnt_nxt   = '0;
        end
      end
      ST_SETTLE: begin
        // Lock loss wins over settle completion in the same cycle
        if (relock_req || lock_bad) begin
          state_nxt = ST_DCM_RST;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (relock_req || lock_bad) begin
          state_nxt = ST_DCM_RST;
          if (lock_bad && (loss_cnt != LOSS_MAX)) begin
            loss_nxt = loss_cnt + LOSS_W'(1);
          end
        end
      end
      ST_FAULT: begin
        cnt_nxt = '0;
        if (relock_req) begin
          state_nxt = ST_DCM_RST;
          retry_nxt = '0;
        end
      end
      default: begin
        state_nxt = ST_DCM_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench for dcm_lock_supervisor with short timing parameters.
module tb_dcm_lock_supervisor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       dcm_locked;
  logic       dcm_clkin_stop;
  logic       relock_req;
  logic       dcm_rst;
  logic       sys_reset;
  logic       clk_ok;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_loss = 0;

  always #5 clk = ~clk;

  dcm_lock_supervisor #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (32),
    .SETTLE_CYCLES(8),
    .MAX_RETRIES  (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .dcm_locked    (dcm_locked),
    .dcm_clkin_stop(dcm_clkin_stop),
    .relock_req    (relock_req),
    .dcm_rst       (dcm_rst),
    .sys_reset     (sys_reset),
    .clk_ok        (clk_ok),
    .fault         (fault),
    .retry_cnt     (retry_cnt),
    .loss_cnt      (loss_cnt)
  );

  // Inputs are driven and outputs sampled on the falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] outs();
    return {dcm_rst, sys_reset, clk_ok, fault, retry_cnt, loss_cnt};
  endfunction

  task automatic wait_clk_ok(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (clk_ok === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic wait_rst(input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dcm_rst === lvl) begin ok = 1'b1; break; end
      tick(1);
    end
  endtask

  task automatic measure_level(input logic lvl, output int n);
    n = 0;
    while (dcm_rst === lvl && n < 200) begin
      n++;
      tick(1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; dcm_locked = 1'b0; dcm_clkin_stop = 1'b0; relock_req = 1'b0;
    tick(3);
    n_checks++; if (outs() !== 16'hC000) begin n_fail++; $display("FAIL reset_outputs got %h want c000", outs()); end
  endtask

  task automatic test_lock_sequence();
    int hi;
    reset_n = 1'b1;
    measure_level(1'b1, hi);
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL seq_rst_width got %0d want 4", hi); end
    tick(10);
    dcm_locked = 1'b1;
    // locked is first sampled one edge later; sys_reset falls 2+8 cycles after that
    tick(10);
    n_checks++; if (sys_reset !== 1'b1) begin n_fail++; $display("FAIL seq_early_release got %b want 1", sys_reset); end
    tick(1);
    n_checks++; if (outs() !== 16'h2000) begin n_fail++; $display("FAIL seq_run_outputs got %h want 2000", outs()); end
  endtask

  task automatic test_lock_loss();
    bit ok;
    dcm_locked = 1'b0; tick(1); dcm_locked = 1'b1; tick(2);
    exp_loss++;
    n_checks++; if ({dcm_rst, sys_reset, clk_ok, fault} !== 4'b1100) begin n_fail++; $display("FAIL loss_reseq got %b want 1100", {dcm_rst, sys_reset, clk_ok, fault}); end
    n_checks++; if (loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL loss_count got %0d want %0d", loss_cnt, exp_loss); end
    wait_clk_ok(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL loss_relock got timeout want clk_ok"); end
    n_checks++; if (retry_cnt !== 4'd0) begin n_fail++; $display("FAIL loss_retry got %0d want 0", retry_cnt); end
  endtask

  task automatic test_relock_in_run();
    int  hi;
    bit  ok;
    relock_req = 1'b1; tick(1); relock_req = 1'b0;
    n_checks++; if ({dcm_rst, sys_reset, clk_ok, fault} !== 4'b1100) begin n_fail++; $display("FAIL relock_reseq got %b want 1100", {dcm_rst, sys_reset, clk_ok, fault}); end
    n_checks++; if (loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL relock_loss got %0d want %0d", loss_cnt, exp_loss); end
    // a second request mid-pulse restarts the full RST width
    tick(2);
    relock_req = 1'b1; tick(1); relock_req = 1'b0;
    measure_level(1'b1, hi);
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL relock_restart_width got %0d want 4", hi); end
    wait_clk_ok(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL relock_run got timeout want clk_ok"); end
  endtask

  task automatic test_clkin_stop();
    bit ok;
    dcm_clkin_stop = 1'b1; tick(1); dcm_clkin_stop = 1'b0; tick(2);
    exp_loss++;
    n_checks++; if ({dcm_rst, sys_reset, clk_ok} !== 3'b110) begin n_fail++; $display("FAIL stop_reseq got %b want 110", {dcm_rst, sys_reset, clk_ok}); end
    n_checks++; if (loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL stop_loss got %0d want %0d", loss_cnt, exp_loss); end
    wait_clk_ok(40, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL stop_run got timeout want clk_ok"); end
  endtask

  task automatic test_settle_loss();
    bit ok;
    relock_req = 1'b1; dcm_locked = 1'b0; tick(1); relock_req = 1'b0;
    n_checks++; if (loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL settle_relock_loss got %0d want %0d", loss_cnt, exp_loss); end
    wait_rst(1'b0, 10, ok);
    wait_rst(1'b1, 60, ok);
    n_checks++; if (!ok || retry_cnt !== 4'd1) begin n_fail++; $display("FAIL settle_pre_retry got %0d want 1", retry_cnt); end
    // k=6 makes the loss coincide with the final settle cycle
    for (int k = 5; k <= 6; k++) begin
      dcm_locked = 1'b1;
      wait_rst(1'b0, 20, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL settle_wait_fall k=%0d got timeout want dcm_rst 0", k); end
      tick(k);
      dcm_locked = 1'b0;
      tick(2);
      n_checks++; if ({dcm_rst, sys_reset, clk_ok} !== 3'b010) begin n_fail++; $display("FAIL settle_hold k=%0d got %b want 010", k, {dcm_rst, sys_reset, clk_ok}); end
      tick(1);
      n_checks++; if ({dcm_rst, sys_reset, clk_ok, retry_cnt} !== 7'b110_0001) begin n_fail++; $display("FAIL settle_abort k=%0d got %b want 1100001", k, {dcm_rst, sys_reset, clk_ok, retry_cnt}); end
    end
    dcm_locked = 1'b1;
    wait_clk_ok(40, ok);
    n_checks++; if (!ok || retry_cnt !== 4'd0) begin n_fail++; $display("FAIL settle_final_run got clk_ok=%b retry=%0d want 1/0", clk_ok, retry_cnt); end
  endtask

  task automatic test_timeout_fault();
    int hi;
    int lo;
    bit ok;
    dcm_locked = 1'b0;
    wait_rst(1'b1, 10, ok);
    exp_loss++;
    n_checks++; if (!ok || loss_cnt !== 8'(exp_loss)) begin n_fail++; $display("FAIL to_entry got loss %0d want %0d", loss_cnt, exp_loss); end
    for (int p = 0; p < 3; p++) begin
      measure_level(1'b1, hi);
      n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL to_pulse%0d_high got %0d want 4", p, hi); end
      if (p < 2) begin
        measure_level(1'b0, lo);
        n_checks++; if (lo !== 32) begin n_fail++; $display("FAIL to_pulse%0d_low got %0d want 32", p, lo); end
        n_checks++; if (retry_cnt !== 4'(p + 1)) begin n_fail++; $display("FAIL to_retry%0d got %0d want %0d", p, retry_cnt, p + 1); end
      end
    end
    tick(31);
    n_checks++; if ({fault, retry_cnt} !== 5'b0_0010) begin n_fail++; $display("FAIL to_last_wait got %b want 00010", {fault, retry_cnt}); end
    tick(1);
    n_checks++; if ({dcm_rst, sys_reset, clk_ok, fault, retry_cnt} !== 8'b0101_0011) begin n_fail++; $display("FAIL to_fault got %b want 01010011", {dcm_rst, sys_reset, clk_ok, fault, retry_cnt}); end
    dcm_locked = 1'b1; tick(8);
    n_checks++; if ({sys_reset, clk_ok, fault} !== 3'b101) begin n_fail++; $display("FAIL to_fault_sticky got %b want 101", {sys_reset, clk_ok, fault}); end
    dcm_locked = 1'b0; tick(3);
    relock_req = 1'b1; tick(1); relock_req = 1'b0;
    n_checks++; if ({dcm_rst, fault, retry_cnt} !== 6'b10_0000) begin n_fail++; $display("FAIL to_recover got %b want 100000", {dcm_rst, fault, retry_cnt}); end
    measure_level(1'b1, hi);
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL to_recover_width got %0d want 4", hi); end
  endtask

  task automatic test_reset_mid_sequence();
    int hi;
    bit ok;
    tick(32);
    n_checks++; if ({dcm_rst, retry_cnt} !== 5'b1_0001) begin n_fail++; $display("FAIL mid_pre_retry got %b want 10001", {dcm_rst, retry_cnt}); end
    wait_rst(1'b0, 10, ok);
    tick(3);
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    exp_loss = 0;
    n_checks++; if (outs() !== 16'hC000) begin n_fail++; $display("FAIL mid_wait_reset got %h want c000", outs()); end
    measure_level(1'b1, hi);
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL mid_wait_width got %0d want 4", hi); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (fault === 1'b1) begin ok = 1'b1; break; end
      tick(1);
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL mid_reach_fault got timeout want fault"); end
    reset_n = 1'b0; tick(1); reset_n = 1'b1;
    n_checks++; if (outs() !== 16'hC000) begin n_fail++; $display("FAIL mid_fault_reset got %h want c000", outs()); end
    measure_level(1'b1, hi);
    n_checks++; if (hi !== 4) begin n_fail++; $display("FAIL mid_fault_width got %0d want 4", hi); end
  endtask

  task automatic test_loss_saturation();
    bit ok;
    int n_to;
    n_to = 0;
    dcm_locked = 1'b1;
    wait_clk_ok(60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL sat_initial_run got timeout want clk_ok"); end
    for (int i = 0; i < 300; i++) begin
      dcm_locked = 1'b0; tick(1); dcm_locked = 1'b1;
      tick(3);
      wait_clk_ok(40, ok);
      if (!ok) n_to++;
      if (i == 253) begin
        n_checks++; if (loss_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_pre got %0d want 254", loss_cnt); end
      end
    end
    n_checks++; if (n_to !== 0) begin n_fail++; $display("FAIL sat_relock got %0d timeouts want 0", n_to); end
    n_checks++; if ({clk_ok, loss_cnt} !== 9'h1FF) begin n_fail++; $display("FAIL sat_final got %h want 1ff", {clk_ok, loss_cnt}); end
  endtask

  initial begin
    test_reset();
    test_lock_sequence();
    test_lock_loss();
    test_relock_in_run();
    test_clkin_stop();
    test_settle_loss();
    test_timeout_fault();
    test_reset_mid_sequence();
    test_loss_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
